// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
//   Parametrised Fibonacci LFSR pseudo-random source with runtime seed load,
//   a valid/ready output stream and recovery from the all-zero lock-up state.
//   With WIDTH=10, TAPS=10'h240 and STEPS=1 the sequence is bit-identical to
//   the earlier fixed 10-bit generator.
//
// Parameters
//   WIDTH  state/output width in bits (3..32)
//   TAPS   feedback mask, bit i set => state[i] feeds the XOR
//   SEED   reset seed, also substituted for an all-zero seed load (non-zero)
//   STEPS  single-bit shifts applied per advance (1..WIDTH)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   global advance enable
//   seed_load  in   seed load request (single-cycle pulse)
//   seed_val   in   seed value, sampled when seed_load=1
//   out_ready  in   consumer ready
//   out_valid  out  rand_val holds a fresh value
//   rand_val   out  current LFSR state
//   lockup     out  sticky: all-zero state seen and recovered; cleared by load
//
// Optional feature (macro LFSR_PERIOD_MON_EN)
//   wrap       out  one-cycle pulse when an advance returns to the last seed
//   adv_cnt    out  advances since last reset/reload, modulo 2^WIDTH
// -----------------------------------------------------------------------------
module lfsr_gen #(
    parameter int unsigned      WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(10'h240),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      STEPS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] rand_val,
    output logic             lockup
`ifdef LFSR_PERIOD_MON_EN
    ,
    output logic             wrap,
    output logic [WIDTH-1:0] adv_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RELOAD = 2'd2
    } fsm_e;

    fsm_e             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic             out_valid_q;
    logic             lockup_q;

    logic [WIDTH-1:0] adv_d;
    logic [WIDTH-1:0] load_d;
    logic             accept;

`ifdef LFSR_PERIOD_MON_EN
    logic [WIDTH-1:0] adv_cnt_q;
    logic [WIDTH-1:0] seed_cap_q;
    logic             wrap_q;
`endif

    // One Fibonacci shift: feedback is the parity of the tapped bits,
    // shifted in at the LSB.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = ^(s & TAPS);
        return {s[WIDTH-2:0], fb};
    endfunction

    always_comb begin
        adv_d = state_q;
        for (int unsigned i = 0; i < STEPS; i++) begin
            adv_d = lfsr_step(adv_d);
        end
        load_d = (seed_val == '0) ? SEED : seed_val;
        accept = (fsm_q == ST_RUN) && out_valid_q && out_ready && enable;
    end

    // Priority: seed load > zero-state recovery > normal handshake.
    // out_valid is registered, so an advance that would land on zero clears
    // it at the same edge; the zero value is therefore never shown as valid,
    // and the following edge substitutes SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_INIT;
            state_q     <= SEED;
            out_valid_q <= 1'b0;
            lockup_q    <= 1'b0;
`ifdef LFSR_PERIOD_MON_EN
            adv_cnt_q   <= '0;
            seed_cap_q  <= SEED;
            wrap_q      <= 1'b0;
`endif
        end else begin
`ifdef LFSR_PERIOD_MON_EN
            wrap_q <= 1'b0;
`endif
            if (seed_load) begin
                fsm_q       <= ST_RELOAD;
                state_q     <= load_d;
                out_valid_q <= 1'b0;
                lockup_q    <= 1'b0;
`ifdef LFSR_PERIOD_MON_EN
                adv_cnt_q   <= '0;
                seed_cap_q  <= load_d;
`endif
            end else if (state_q == '0) begin
                fsm_q       <= ST_RUN;
                state_q     <= SEED;
                out_valid_q <= 1'b1;
                lockup_q    <= 1'b1;
            end else begin
                unique case (fsm_q)
                    ST_INIT, ST_RELOAD: begin
                        fsm_q       <= ST_RUN;
                        out_valid_q <= 1'b1;
                    end
                    ST_RUN: begin
                        if (accept) begin
                            state_q     <= adv_d;
                            out_valid_q <= (adv_d != '0);
`ifdef LFSR_PERIOD_MON_EN
                            adv_cnt_q   <= adv_cnt_q + WIDTH'(1);
                            wrap_q      <= (adv_d == seed_cap_q);
`endif
                        end else begin
                            out_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        fsm_q       <= ST_INIT;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign rand_val  = state_q;
    assign lockup    = lockup_q;

`ifdef LFSR_PERIOD_MON_EN
    assign wrap    = wrap_q;
    assign adv_cnt = adv_cnt_q;
`endif

endmodule
